// File: rtl/prbs_byte_checker.sv
// prbs_byte_checker: self-synchronising checker for the 128-bit LFSR byte stream.
// Locks onto incoming PRBS bytes, then counts bit errors against a regenerated copy.
module prbs_byte_checker #(
  parameter int LOCK_BYTES = 4,
  parameter int LOSS_BYTES = 8,
  parameter int BAD_BITS   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_counts,
  input  logic        input_strobe,
  input  logic [7:0]  data_in,
  output logic        output_strobe,
  output logic [7:0]  err_bits,
  output logic        locked,
  output logic [31:0] bit_err_count,
  output logic [31:0] byte_count
);

  typedef enum logic [1:0] {
    FILL,
    VERIFY,
    LOCKED
  } state_t;

  localparam logic [7:0] LOCK_N = 8'(LOCK_BYTES);
  localparam logic [7:0] LOSS_N = 8'(LOSS_BYTES);
  localparam logic [3:0] BAD_N  = 4'(BAD_BITS);

  state_t       state_q, state_d;
  logic [7:0]   fill_q, fill_d;
  logic [7:0]   run_q, run_d;
  logic [127:0] hist_q, hist_d;
  logic [7:0]   pred;
  logic [7:0]   err;
  logic [3:0]   nerr;
  logic [7:0]   shin;
  logic         ostb_q, ostb_d;
  logic         lock_q, lock_d;
  logic [7:0]   err_q, err_d;
  logic [31:0]  bec_q, bec_d;
  logic [31:0]  byc_q, byc_d;
  logic [32:0]  bec_sum, byc_sum;

  // hist[0] is the newest bit; all taps sit at index >= 91 so a byte is one step
  always_comb begin
    pred = '0;
    nerr = '0;
    for (int i = 0; i < 8; i++) begin
      pred[i] = hist_q[127-i] ^ hist_q[125-i]
              ^ hist_q[100-i] ^ hist_q[98-i];
    end
    err = data_in ^ pred;
    for (int i = 0; i < 8; i++) begin
      nerr = nerr + 4'(err[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FILL;
      fill_q  <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    run_d   = run_q;
    if (input_strobe) begin
      unique case (state_q)
        FILL: begin
          fill_d = fill_q + 8'd8;
          if (fill_q == 8'd120) begin
            state_d = VERIFY;
            run_d   = '0;
          end
        end
        VERIFY: begin
          if (nerr == '0) begin
            run_d = run_q + 8'd1;
            if (run_q + 8'd1 == LOCK_N) begin
              state_d = LOCKED;
              run_d   = '0;
            end
          end else begin
            state_d = FILL;
            fill_d  = '0;
            run_d   = '0;
          end
        end
        LOCKED: begin
          if (nerr >= BAD_N) begin
            run_d = run_q + 8'd1;
            if (run_q + 8'd1 == LOSS_N) begin
              state_d = FILL;
              fill_d  = '0;
              run_d   = '0;
            end
          end else begin
            run_d = '0;
          end
        end
        default: begin
          state_d = FILL;
          fill_d  = '0;
          run_d   = '0;
        end
      endcase
    end
  end

  // when locked, the history follows the prediction so errors never propagate
  always_comb begin
    shin = '0;
    for (int i = 0; i < 8; i++) begin
      shin[7-i] = (state_q == LOCKED) ? pred[i] : data_in[i];
    end
    bec_sum = {1'b0, bec_q} + 33'(nerr);
    byc_sum = {1'b0, byc_q} + 33'd1;
    hist_d  = hist_q;
    ostb_d  = input_strobe;
    err_d   = err_q;
    lock_d  = (state_d == LOCKED);
    bec_d   = bec_q;
    byc_d   = byc_q;
    if (input_strobe) begin
      hist_d = {hist_q[119:0], shin};
      err_d  = (state_q == FILL) ? 8'h00 : err;
      if (state_q == LOCKED) begin
        bec_d = bec_sum[32] ? '1 : bec_sum[31:0];
        byc_d = byc_sum[32] ? '1 : byc_sum[31:0];
      end
    end
    if (clear_counts) begin
      bec_d = '0;
      byc_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= '0;
      ostb_q <= 1'b0;
      err_q  <= '0;
      lock_q <= 1'b0;
      bec_q  <= '0;
      byc_q  <= '0;
    end else begin
      hist_q <= hist_d;
      ostb_q <= ostb_d;
      err_q  <= err_d;
      lock_q <= lock_d;
      bec_q  <= bec_d;
      byc_q  <= byc_d;
    end
  end

  assign output_strobe = ostb_q;
  assign err_bits      = err_q;
  assign locked        = lock_q;
  assign bit_err_count = bec_q;
  assign byte_count    = byc_q;

endmodule

// File: tb/tb_prbs_byte_checker.sv
// tb_prbs_byte_checker: scoreboard bench for prbs_byte_checker.
// A bit-serial reference model predicts every output strobe.
module tb_prbs_byte_checker;

  localparam int LOCK_BYTES = 4;
  localparam int LOSS_BYTES = 8;
  localparam int BAD_BITS   = 3;

  logic        clock;
  logic        reset;
  logic        clear_counts;
  logic        input_strobe;
  logic [7:0]  data_in;
  logic        output_strobe;
  logic [7:0]  err_bits;
  logic        locked;
  logic [31:0] bit_err_count;
  logic [31:0] byte_count;

  prbs_byte_checker #(
    .LOCK_BYTES(LOCK_BYTES),
    .LOSS_BYTES(LOSS_BYTES),
    .BAD_BITS(BAD_BITS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .clear_counts(clear_counts),
    .input_strobe(input_strobe),
    .data_in(data_in),
    .output_strobe(output_strobe),
    .err_bits(err_bits),
    .locked(locked),
    .bit_err_count(bit_err_count),
    .byte_count(byte_count)
  );

  typedef struct packed {
    logic [7:0]  err;
    logic        lk;
    logic [31:0] bec;
    logic [31:0] byc;
  } exp_t;

  exp_t sb[$];
  exp_t mex;
  int   checks;
  int   fails;
  int   out_idx;
  int   first_lock;

  bit     hq[$];
  bit     gq[$];
  int     mode;
  int     fillb;
  int     run;
  longint mbec;
  longint mbyc;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic void mreset();
    hq.delete();
    repeat (128) hq.push_back(1'b0);
    mode  = 0;
    fillb = 0;
    run   = 0;
    mbec  = 0;
    mbyc  = 0;
  endfunction

  // stream is the recurrence b[n] = b[n-128]^b[n-126]^b[n-101]^b[n-99]
  function automatic void seed_gen(input bit alt);
    gq.delete();
    for (int k = 0; k < 128; k++) begin
      if (alt) gq.push_back(k % 2 == 0);
      else gq.push_back(bit'($urandom_range(0, 1)));
    end
  endfunction

  function automatic logic [7:0] gen_byte();
    logic [7:0] b;
    bit nb;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      nb = gq[0] ^ gq[2] ^ gq[27] ^ gq[29];
      b[i] = nb;
      gq.push_back(nb);
      void'(gq.pop_front());
    end
    return b;
  endfunction

  task automatic model(input logic [7:0] d, input bit clr,
                       output exp_t ex);
    logic [7:0] e;
    int n;
    bit pb;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      pb = hq[0] ^ hq[2] ^ hq[27] ^ hq[29];
      e[i] = d[i] ^ pb;
      hq.push_back(mode == 2 ? pb : bit'(d[i]));
      void'(hq.pop_front());
    end
    n = $countones(e);
    ex.err = (mode == 0) ? 8'h00 : e;
    if (mode == 2) begin
      mbec = mbec + n;
      mbyc = mbyc + 1;
      if (mbec > 64'hFFFF_FFFF) mbec = 64'hFFFF_FFFF;
      if (mbyc > 64'hFFFF_FFFF) mbyc = 64'hFFFF_FFFF;
    end
    if (mode == 0) begin
      fillb++;
      if (fillb == 16) begin
        mode = 1;
        run  = 0;
      end
    end else if (mode == 1) begin
      if (n == 0) begin
        run++;
        if (run == LOCK_BYTES) begin
          mode = 2;
          run  = 0;
        end
      end else begin
        mode  = 0;
        fillb = 0;
        run   = 0;
      end
    end else begin
      if (n >= BAD_BITS) run++;
      else run = 0;
      if (run == LOSS_BYTES) begin
        mode  = 0;
        fillb = 0;
        run   = 0;
      end
    end
    if (clr) begin
      mbec = 0;
      mbyc = 0;
    end
    ex.lk  = (mode == 2);
    ex.bec = 32'(mbec);
    ex.byc = 32'(mbyc);
  endtask

  always @(negedge clock) begin
    if (output_strobe) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_spurious: output_strobe with no expected entry");
      end else begin
        mex = sb.pop_front();
        out_idx++;
        chk("sb_err_bits", 32'(err_bits), 32'(mex.err));
        chk("sb_locked", 32'(locked), 32'(mex.lk));
        chk("sb_bit_err_count", bit_err_count, mex.bec);
        chk("sb_byte_count", byte_count, mex.byc);
        if (locked && first_lock == 0) first_lock = out_idx;
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit clr);
    exp_t ex;
    model(d, clr, ex);
    input_strobe = 1'b1;
    data_in      = d;
    clear_counts = clr;
    sb.push_back(ex);
    @(negedge clock);
    input_strobe = 1'b0;
    clear_counts = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_clear();
    clear_counts = 1'b1;
    mbec = 0;
    mbyc = 0;
    @(negedge clock);
    clear_counts = 1'b0;
  endtask

  task automatic do_reset(input bit with_stb);
    reset        = 1'b1;
    input_strobe = with_stb;
    data_in      = 8'($urandom);
    @(negedge clock);
    reset        = 1'b0;
    input_strobe = 1'b0;
    mreset();
    out_idx    = 0;
    first_lock = 0;
    chk("rst_sb_empty", 32'(sb.size()), 32'd0);
    chk("rst_output_strobe", 32'(output_strobe), 32'd0);
    chk("rst_err_bits", 32'(err_bits), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_bit_err_count", bit_err_count, 32'd0);
    chk("rst_byte_count", byte_count, 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] fl;
    int burst;
    checks       = 0;
    fails        = 0;
    reset        = 1'b1;
    clear_counts = 1'b0;
    input_strobe = 1'b0;
    data_in      = '0;
    mreset();
    idle(2);
    do_reset(1'b0);

    // clean lock from the alternating seed
    seed_gen(1'b1);
    for (int k = 1; k <= 40; k++) send(gen_byte(), 1'b0);
    idle(2);
    chk("clean_first_lock", 32'(first_lock), 32'd20);
    chk("clean_locked", 32'(locked), 32'd1);
    chk("clean_bec", bit_err_count, 32'd0);
    chk("clean_byc", byte_count, 32'd20);

    // single-bit error while locked
    do_reset(1'b0);
    seed_gen(1'b0);
    for (int k = 1; k <= 40; k++) begin
      d = gen_byte();
      if (k == 30) d = d ^ 8'h08;
      send(d, 1'b0);
      if (k == 30) begin
        chk("lk_err30", 32'(err_bits), 32'h08);
        chk("lk_bec30", bit_err_count, 32'd1);
        chk("lk_locked30", 32'(locked), 32'd1);
      end
      if (k == 31) chk("lk_err31", 32'(err_bits), 32'h00);
    end
    idle(2);
    chk("lk_byc", byte_count, 32'd20);

    // error during verify, then loss of lock and relock
    do_reset(1'b0);
    seed_gen(1'b0);
    for (int k = 1; k <= 45; k++) begin
      d = gen_byte();
      if (k == 18) d = d ^ 8'h01;
      send(d, 1'b0);
      if (k == 18) begin
        chk("ver_err18", 32'(err_bits), 32'h01);
        chk("ver_locked18", 32'(locked), 32'd0);
      end
    end
    idle(1);
    chk("ver_first_lock", 32'(first_lock), 32'd38);
    for (int k = 1; k <= 8; k++) begin
      send(gen_byte() ^ 8'hFF, 1'b0);
      if (k == 7) chk("loss_locked7", 32'(locked), 32'd1);
    end
    chk("loss_locked8", 32'(locked), 32'd0);
    chk("loss_bec", bit_err_count, 32'd64);
    for (int k = 1; k <= 20; k++) begin
      send(gen_byte(), 1'b0);
      if (k == 19) chk("relock19", 32'(locked), 32'd0);
    end
    chk("relock20", 32'(locked), 32'd1);

    // gapped strobes, then clear coinciding with an errored byte
    do_reset(1'b0);
    seed_gen(1'b1);
    for (int k = 1; k <= 40; k++) begin
      d = gen_byte();
      if (k == 30) d = d ^ 8'h08;
      send(d, 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(1);
    chk("gap_first_lock", 32'(first_lock), 32'd20);
    chk("gap_bec", bit_err_count, 32'd1);
    chk("gap_byc", byte_count, 32'd20);
    send(gen_byte() ^ 8'h10, 1'b1);
    chk("clr_err", 32'(err_bits), 32'h10);
    chk("clr_bec", bit_err_count, 32'd0);
    chk("clr_byc", byte_count, 32'd0);
    chk("clr_locked", 32'(locked), 32'd1);

    // reset while locked, with a strobe that must be ignored
    idle(1);
    do_reset(1'b1);
    for (int k = 1; k <= 20; k++) begin
      send(gen_byte(), 1'b0);
      if (k == 19) chk("rst_relock19", 32'(locked), 32'd0);
    end
    chk("rst_relock20", 32'(locked), 32'd1);

    // random soak: sparse errors, bursts, clears and gaps
    do_reset(1'b0);
    seed_gen(1'b0);
    burst = 0;
    for (int k = 0; k < 800; k++) begin
      fl = '0;
      if (burst > 0) begin
        fl = 8'($urandom) | 8'h07;
        burst--;
      end else if ($urandom_range(0, 149) == 0) begin
        burst = $urandom_range(4, 10);
      end else if ($urandom_range(0, 99) < 4) begin
        fl = 8'($urandom);
      end
      send(gen_byte() ^ fl, $urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) pulse_clear();
      idle($urandom_range(0, 1));
    end

    idle(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
